// File: rtl/rsa_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_arb_pkg
//  Description : Shared state encoding and default sizes for the RSA core
//                arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_arb_pkg;

  localparam int C_WIDTH_DEFAULT = 256;
  localparam int C_NREQ_DEFAULT  = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Two-way round-robin pick; the requester that was not served
//                last wins a tie, a lone requester always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       index
);

  logic w_other;

  assign w_other = ~last;

  always_comb begin
    grant = 2'b00;
    index = 1'b0;
    if (req[w_other]) begin
      grant[w_other] = 1'b1;
      index          = w_other;
    end else if (req[last]) begin
      grant[last] = 1'b1;
      index       = last;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rsa_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_core_arbiter
//  Description : Shares one modular-exponentiation core between two
//                requesters with round-robin arbitration and a held response.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_core_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT,
  parameter int NREQ  = C_NREQ_DEFAULT
) (
  input  logic                  avm_clk,
  input  logic                  avm_rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_e,
  input  logic [NREQ*WIDTH-1:0] req_n,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  core_start,
  output logic [WIDTH-1:0]      core_a,
  output logic [WIDTH-1:0]      core_e,
  output logic [WIDTH-1:0]      core_n,
  input  logic [WIDTH-1:0]      core_result,
  input  logic                  core_finished,
  output logic                  busy,
  output logic                  grant_id,
  output logic [31:0]           op_count,
  output logic                  err_spurious
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_core_a;
  logic [WIDTH-1:0] r_core_e;
  logic [WIDTH-1:0] r_core_n;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_grant_id;
  logic             r_last_served;
  logic [31:0]      r_op_count;
  logic             r_err_spurious;

  logic [1:0]       w_grant;
  logic             w_grant_idx;
  logic             w_in_idle;
  logic             w_in_resp;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             w_spurious;
  logic             w_capture;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_e;
  logic [WIDTH-1:0] w_sel_n;

  rr_arbiter u_rr_arbiter (
    .req   (req_valid),
    .last  (r_last_served),
    .grant (w_grant),
    .index (w_grant_idx)
  );

  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_resp = (r_state == S_RESP);

  assign w_sel_a = w_grant_idx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
  assign w_sel_e = w_grant_idx ? req_e[WIDTH +: WIDTH] : req_e[0 +: WIDTH];
  assign w_sel_n = w_grant_idx ? req_n[WIDTH +: WIDTH] : req_n[0 +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    w_spurious  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_spurious = core_finished;
        if (|w_grant) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      // A finish pulse here cannot belong to this launch, so it is dropped.
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_finished) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_spurious = core_finished;
        if (rsp_ready[r_grant_id]) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_core_a       <= '0;
      r_core_e       <= '0;
      r_core_n       <= '0;
      r_rsp_data     <= '0;
      r_grant_id     <= 1'b0;
      r_last_served  <= 1'b1;
      r_op_count     <= 32'd0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_accept) begin
        r_core_a   <= w_sel_a;
        r_core_e   <= w_sel_e;
        r_core_n   <= w_sel_n;
        r_grant_id <= w_grant_idx;
      end
      if (w_capture) begin
        r_rsp_data <= core_result;
      end
      if (w_rsp_hs) begin
        r_last_served <= r_grant_id;
        r_op_count    <= r_op_count + 32'd1;
      end
      if (w_spurious) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

  // Reset gates the accept path so no handshake is offered while held in reset.
  assign req_ready = (w_in_idle && avm_rst_n) ? w_grant : '0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp_valid
    assign rsp_valid[gi] = w_in_resp && (int'(r_grant_id) == gi);
  end

  assign rsp_data     = r_rsp_data;
  assign core_start   = (r_state == S_LAUNCH);
  assign core_a       = r_core_a;
  assign core_e       = r_core_e;
  assign core_n       = r_core_n;
  assign busy         = ~w_in_idle;
  assign grant_id     = r_grant_id;
  assign op_count     = r_op_count;
  assign err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_rsa_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_core_arbiter
//  Description : Randomised self-checking bench with a request-level model of
//                the arbiter and a behavioural exponentiation core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_core_arbiter;

  localparam int W = 32;

  logic           avm_clk = 1'b0;
  logic           avm_rst_n;
  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*W-1:0] req_a, req_e, req_n;
  logic [W-1:0]   rsp_data, core_a, core_e, core_n, core_result;
  logic           core_start, core_finished, busy, grant_id, err_spurious;
  logic [31:0]    op_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Request-level model state
  bit           pv [2];
  logic [W-1:0] pa [2];
  logic [W-1:0] pe [2];
  logic [W-1:0] pn [2];
  int           m_last;
  int unsigned  m_ops;
  bit           m_err;

  rsa_core_arbiter #(.WIDTH(W), .NREQ(2)) dut (
    .avm_clk       (avm_clk),
    .avm_rst_n     (avm_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_e         (req_e),
    .req_n         (req_n),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .core_start    (core_start),
    .core_a        (core_a),
    .core_e        (core_e),
    .core_n        (core_n),
    .core_result   (core_result),
    .core_finished (core_finished),
    .busy          (busy),
    .grant_id      (grant_id),
    .op_count      (op_count),
    .err_spurious  (err_spurious)
  );

  always #5 avm_clk = ~avm_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    longint unsigned r, b;
    r = 1;
    b = 64'(a) % 64'(n);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % 64'(n);
      b = (b * b) % 64'(n);
    end
    return W'(r);
  endfunction

  task automatic new_ops(input int i);
    pv[i] = 1'b1;
    pa[i] = $urandom;
    pe[i] = $urandom;
    pn[i] = $urandom;
    if (pn[i] < 2) pn[i] = 2;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]     = pv[i];
      req_a[i*W +: W]  = pa[i];
      req_e[i*W +: W]  = pe[i];
      req_n[i*W +: W]  = pn[i];
    end
  endtask

  function automatic int pick();
    if (pv[0] && pv[1]) return 1 - m_last;
    if (pv[0]) return 0;
    return 1;
  endfunction

  // One complete operation; entered and left just after a falling edge.
  task automatic run_op(input int bp, input bit stray_rdy, input bit launch_noise,
                        input bit resp_noise);
    int           w;
    int           d;
    logic [1:0]   oh;
    logic [W-1:0] exp_res;
    w       = pick();
    oh      = 2'b01 << w;
    exp_res = modexp(pa[w], pe[w], pn[w]);
    drive_reqs();
    #1;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("req_ready", 64'(req_ready), 64'(oh));
    chk("err_sticky", 64'(err_spurious), 64'(m_err));
    @(negedge avm_clk);
    pv[w] = 1'b0;
    drive_reqs();
    if (launch_noise) begin
      core_finished = 1'b1;
      core_result   = $urandom;
    end
    #1;
    chk("core_start", 64'(core_start), 64'(1));
    chk("grant_id", 64'(grant_id), 64'(w));
    chk("core_a", 64'(core_a), 64'(pa[w]));
    chk("core_e", 64'(core_e), 64'(pe[w]));
    chk("core_n", 64'(core_n), 64'(pn[w]));
    chk("ready_busy", 64'(req_ready), 64'(0));
    d = $urandom_range(1, 4);
    for (int k = 0; k < d; k++) begin
      @(negedge avm_clk);
      core_finished = 1'b0;
      #1;
      chk("wait_start", 64'(core_start), 64'(0));
      chk("wait_rsp", 64'(rsp_valid), 64'(0));
      chk("wait_a", 64'(core_a), 64'(pa[w]));
    end
    @(negedge avm_clk);
    core_finished = 1'b1;
    core_result   = exp_res;
    @(negedge avm_clk);
    core_finished = 1'b0;
    core_result   = $urandom;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_data", 64'(rsp_data), 64'(exp_res));
    for (int k = 0; k < bp; k++) begin
      rsp_ready     = stray_rdy ? (2'b01 << (1 - w)) : 2'b00;
      core_finished = resp_noise && (k == 0);
      if (resp_noise && k == 0) m_err = 1'b1;
      @(negedge avm_clk);
      core_finished = 1'b0;
      #1;
      chk("bp_valid", 64'(rsp_valid), 64'(oh));
      chk("bp_data", 64'(rsp_data), 64'(exp_res));
      chk("bp_ready", 64'(req_ready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_err", 64'(err_spurious), 64'(m_err));
    end
    rsp_ready = oh;
    @(negedge avm_clk);
    rsp_ready = 2'b00;
    m_ops++;
    m_last = w;
    #1;
    chk("op_count", 64'(op_count), 64'(m_ops));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_rsp", 64'(rsp_valid), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_start"}, 64'(core_start), 64'(0));
    chk({tag, "_rdy"}, 64'(req_ready), 64'(0));
    chk({tag, "_rspv"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_gid"}, 64'(grant_id), 64'(0));
    chk({tag, "_err"}, 64'(err_spurious), 64'(0));
    chk({tag, "_cnt"}, 64'(op_count), 64'(0));
    chk({tag, "_a"}, 64'({core_a, core_e}), 64'(0));
    chk({tag, "_n"}, 64'(core_n), 64'(0));
    chk({tag, "_data"}, 64'(rsp_data), 64'(0));
  endtask

  initial begin
    avm_rst_n     = 1'b1;
    req_valid     = 2'b00;
    req_a         = '0;
    req_e         = '0;
    req_n         = '0;
    rsp_ready     = 2'b00;
    core_result   = '0;
    core_finished = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pe[i] = '0; pn[i] = 2;
    end
    m_last = 1;
    m_ops  = 0;
    m_err  = 1'b0;

    #1 avm_rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge avm_clk);
    avm_rst_n = 1'b1;

    // Both valid straight after reset: requester 0 then 1
    new_ops(0);
    new_ops(1);
    run_op(0, 0, 0, 0);
    run_op(1, 0, 0, 0);

    // Single request with known operands: 5^3 mod 33 = 26
    pv[0] = 1'b1; pa[0] = 5; pe[0] = 3; pn[0] = 33;
    run_op(0, 0, 0, 0);
    chk("known_result", 64'(rsp_data), 64'(26));

    // Stray finish while idle
    drive_reqs();
    core_finished = 1'b1;
    @(negedge avm_clk);
    core_finished = 1'b0;
    m_err = 1'b1;
    #1;
    chk("spur_err", 64'(err_spurious), 64'(1));
    chk("spur_busy", 64'(busy), 64'(0));
    chk("spur_cnt", 64'(op_count), 64'(m_ops));

    // Long response backpressure with the other requester poking rsp_ready
    new_ops(1);
    run_op(10, 1, 0, 1);

    // Reset while the core is busy; the request is reissued afterwards
    new_ops(0);
    drive_reqs();
    @(negedge avm_clk);
    pv[0] = 1'b0;
    drive_reqs();
    @(negedge avm_clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2 avm_rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check_reset_outputs("midrst");
    m_ops  = 0;
    m_last = 1;
    m_err  = 1'b0;
    pv[0]  = 1'b1;
    repeat (2) @(negedge avm_clk);
    avm_rst_n = 1'b1;
    run_op(1, 0, 0, 0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 2; i++)
        if (!pv[i] && (r < 4 || $urandom_range(0, 1) == 1)) new_ops(i);
      if (!pv[0] && !pv[1]) new_ops(int'($urandom_range(0, 1)));
      run_op(int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_core_arbiter.md
RSA_CORE_ARBITER -- requirements
Module: rsa_core_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 256: operand and result width in bits.
REQ-002 SHALL have parameter NREQ, default 2: number of requesters; only 2 is supported.
REQ-003 SHALL have port avm_clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port avm_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, NREQ bits: per-requester operation request.
REQ-006 SHALL have port req_ready, output, NREQ bits: per-requester accept.
REQ-007 SHALL have ports req_a, req_e, req_n, inputs, NREQ x WIDTH: per-requester base, exponent, modulus.
REQ-008 SHALL have port rsp_valid, output, NREQ bits: result available to that requester.
REQ-009 SHALL have port rsp_ready, input, NREQ bits: requester takes the result.
REQ-010 SHALL have port rsp_data, output, WIDTH: shared result bus, valid only with rsp_valid.
REQ-011 SHALL have port core_start, output, 1 bit: start pulse to the exponentiation core.
REQ-012 SHALL have ports core_a, core_e, core_n, outputs, WIDTH: registered operands to the core.
REQ-013 SHALL have port core_result, input, WIDTH: core output a^e mod n.
REQ-014 SHALL have port core_finished, input, 1 bit: core completion pulse.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except S_IDLE.
REQ-016 SHALL have port grant_id, output, 1 bit: index of the requester currently served.
REQ-017 SHALL have port op_count, output, 32 bits: number of completed operations.
REQ-018 SHALL have port err_spurious, output, 1 bit: sticky flag for unexpected core_finished.

Function
REQ-019 SHALL implement four states: S_IDLE, S_LAUNCH, S_WAIT, S_RESP.
REQ-020 In S_IDLE, SHALL pick a winner combinationally among asserted req_valid by round-robin and drive req_ready high for the winner only, same cycle.
REQ-021 Round-robin SHALL give priority to the requester other than last_served; when only one requester is valid, that requester SHALL win regardless.
REQ-022 On req_valid&req_ready, SHALL latch req_a/e/n of the winner into core_a/e/n, set grant_id, and go to S_LAUNCH.
REQ-023 In S_LAUNCH, SHALL assert core_start for exactly one cycle, then go to S_WAIT.
REQ-024 In S_WAIT, SHALL hold core_start=0 and keep core_a/e/n stable.
REQ-025 In S_WAIT, on core_finished=1 SHALL register core_result into rsp_data and go to S_RESP.
REQ-026 SHALL ignore core_finished sampled during S_LAUNCH.
REQ-027 In S_RESP, SHALL assert rsp_valid[grant_id] only and hold rsp_data until rsp_ready[grant_id].
REQ-028 On the S_RESP handshake, SHALL set last_served=grant_id, increment op_count (wrapping 2^32-1 -> 0), and go to S_IDLE.
REQ-029 rsp_ready from the non-granted requester SHALL have no effect.
REQ-030 req_ready SHALL be 0 outside S_IDLE; req_valid held across a busy period SHALL be served later, with no loss.
REQ-031 Latency: accept at cycle t gives core_start at t+1; rsp_valid is seen the cycle after core_finished is sampled.
REQ-032 core_finished=1 in S_IDLE or S_RESP SHALL set err_spurious=1 (sticky until reset) and SHALL NOT change state or data.

Reset
REQ-033 On avm_rst_n=0, SHALL immediately set: state=S_IDLE; core_start, req_ready, rsp_valid, busy, grant_id, err_spurious = 0; op_count, core_a/e/n, rsp_data = 0; last_served=1, so requester 0 has first priority.
REQ-034 Reset during an operation SHALL drop the in-flight request without a response; the requester SHALL reissue it.

Structure
REQ-035 Package rsa_arb_pkg SHALL hold the state enum and the WIDTH default constant.
REQ-036 Round-robin selection SHALL be a sub-module, rr_arbiter: inputs req and last; outputs one-hot grant and index.

Verification
REQ-037 Single request: req_valid=01, a=5, e=3, n=33; core model returns 26 -> core_start one cycle after accept, rsp_valid=01, rsp_data=26, op_count=1.
REQ-038 Simultaneous requests after reset: req_valid=11 -> requester 0 served first, requester 1 second, grant_id sequence 0,1.
REQ-039 Back-to-back both-valid for 4 ops -> grant alternates 0,1,0,1; no requester starves.
REQ-040 Response backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, no new accept, busy=1.
REQ-041 core_finished pulsed in S_IDLE -> err_spurious=1, state stays S_IDLE, op_count unchanged.
REQ-042 avm_rst_n low during S_WAIT -> all outputs 0 asynchronously, no response, next request accepted normally.
